instr_field_encoder_loader: RTL and testbench



---
 rtl/instr_field_encoder_loader_pkg.sv | 34 +++
 rtl/instr_word_pack.sv | 40 ++++
 rtl/instr_field_encoder_loader.sv | 99 +++++++++
 tb/tb_instr_field_encoder_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_field_encoder_loader_pkg.sv
// Shared definitions for the RV32I field encoder/loader: opcode constants,
// loader FSM state encodings and the decoded-field bundle.
package instr_field_encoder_loader_pkg;

   localparam logic [6:0] OP_R     = 7'h33;
   localparam logic [6:0] OP_I     = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_S     = 7'h23;
   localparam logic [6:0] OP_SB    = 7'h63;
   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENCODE,
      ST_WRITE,
      ST_DONE,
      ST_FULL
   } state_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        last;
   } fields_t;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational RV32I packer: decoded fields in, 32-bit instruction word and
// an illegal-opcode flag out.
module instr_word_pack
   import instr_field_encoder_loader_pkg::*;
(
   input  fields_t     fld,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      unique case (fld.opcode)
         OP_R:
            word = {fld.funct7, fld.rs2, fld.rs1, fld.funct3, fld.rd, fld.opcode};
         OP_I: begin
            // Shift-immediates carry funct7 above a 5-bit shift amount
            if (fld.funct3 == 3'b001 || fld.funct3 == 3'b101)
               word = {fld.funct7, fld.imm[4:0], fld.rs1, fld.funct3, fld.rd, fld.opcode};
            else
               word = {fld.imm[11:0], fld.rs1, fld.funct3, fld.rd, fld.opcode};
         end
         OP_LOAD, OP_JALR:
            word = {fld.imm[11:0], fld.rs1, fld.funct3, fld.rd, fld.opcode};
         OP_S:
            word = {fld.imm[11:5], fld.rs2, fld.rs1, fld.funct3, fld.imm[4:0], fld.opcode};
         OP_SB:
            word = {fld.imm[12], fld.imm[10:5], fld.rs2, fld.rs1, fld.funct3,
                    fld.imm[4:1], fld.imm[11], fld.opcode};
         OP_LUI, OP_AUIPC:
            word = {fld.imm[31:12], fld.rd, fld.opcode};
         OP_JAL:
            word = {fld.imm[20], fld.imm[10:1], fld.imm[11], fld.imm[19:12], fld.rd, fld.opcode};
         default:
            illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_field_encoder_loader.sv
// Accepts decoded RV32I field bundles, packs each into an instruction word and
// writes the words sequentially into IMEM (one word per three cycles).
module instr_field_encoder_loader
   import instr_field_encoder_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rdAddr,
   input  logic [4:0]        rs1Addr,
   input  logic [4:0]        rs2Addr,
   input  logic [31:0]       imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              full,
   output logic              err_illegal
);

   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

   state_t      state, state_nxt;
   fields_t     fld;
   logic [31:0] word;
   logic        illegal;
   logic        at_top;

   instr_word_pack u_pack (
      .fld     (fld),
      .word    (word),
      .illegal (illegal)
   );

   assign at_top   = (count == LAST_CNT);
   assign in_ready = (state == ST_IDLE);
   assign imem_we  = (state == ST_WRITE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (in_valid) state_nxt = ST_ENCODE;
         ST_ENCODE: state_nxt = illegal ? ST_IDLE : ST_WRITE;
         ST_WRITE: begin
            if (fld.last)    state_nxt = ST_DONE;
            else if (at_top) state_nxt = ST_FULL;
            else             state_nxt = ST_IDLE;
         end
         ST_DONE:   state_nxt = ST_DONE;
         ST_FULL:   state_nxt = ST_FULL;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state       <= ST_IDLE;
         fld         <= '0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         count       <= '0;
         done        <= 1'b0;
         full        <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         state       <= state_nxt;
         err_illegal <= 1'b0;
         unique case (state)
            ST_IDLE:
               if (in_valid)
                  fld <= '{opcode, funct3, funct7, rdAddr, rs1Addr, rs2Addr, imm, in_last};
            ST_ENCODE: begin
               imem_wdata  <= word;
               err_illegal <= illegal;
            end
            ST_WRITE: begin
               count <= count + 1'b1;
               // Saturate at the last word so the address never wraps to 0
               if (imem_addr != TOP_ADDR) imem_addr <= imem_addr + 1'b1;
               done  <= fld.last;
               full  <= at_top;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_field_encoder_loader.sv
// Directed, table-driven bench for the field encoder/loader: a default-size
// instance and a DEPTH=4 instance for the full/address-saturation corners.
module tb_instr_field_encoder_loader;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        last;
      logic        ill;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        valid_a = 1'b0, valid_b = 1'b0;
   logic        in_last = 1'b0;
   logic [6:0]  opcode = '0, funct7 = '0;
   logic [2:0]  funct3 = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0] imm = '0;

   logic        rdy_a, we_a, done_a, full_a, err_a;
   logic [7:0]  addr_a;
   logic [8:0]  cnt_a;
   logic [31:0] wdata_a;
   logic        rdy_b, we_b, done_b, full_b, err_b;
   logic [1:0]  addr_b;
   logic [2:0]  cnt_b;
   logic [31:0] wdata_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_field_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(valid_a), .in_ready(rdy_a),
      .in_last(in_last), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rdAddr(rd), .rs1Addr(rs1), .rs2Addr(rs2), .imm(imm),
      .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .count(cnt_a),
      .done(done_a), .full(full_a), .err_illegal(err_a));

   instr_field_encoder_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(valid_b), .in_ready(rdy_b),
      .in_last(in_last), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rdAddr(rd), .rs1Addr(rs1), .rs2Addr(rs2), .imm(imm),
      .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .count(cnt_b),
      .done(done_b), .full(full_b), .err_illegal(err_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present a bundle and complete the handshake on the chosen instance.
   task automatic send(input vec_t v, input bit b);
      int n;
      opcode = v.op; funct3 = v.f3; funct7 = v.f7; rd = v.rd;
      rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; in_last = v.last;
      n = 0;
      while (!(b ? rdy_b : rdy_a) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
      if (b) valid_b = 1'b1; else valid_a = 1'b1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   task automatic xfer(input vec_t v, input bit b, input logic [31:0] ea, input logic [31:0] ec);
      send(v, b);
      @(negedge clk);
      chk("encode_no_we", {31'd0, b ? we_b : we_a}, 32'd0);
      @(negedge clk);
      if (v.ill) begin
         chk("err_pulse", {31'd0, b ? err_b : err_a}, 32'd1);
         chk("ill_no_we", {31'd0, b ? we_b : we_a}, 32'd0);
      end else begin
         chk("we", {31'd0, b ? we_b : we_a}, 32'd1);
         chk("wdata", b ? wdata_b : wdata_a, v.exp);
         chk("addr", b ? {30'd0, addr_b} : {24'd0, addr_a}, ea);
      end
      @(negedge clk);
      chk("err_low", {31'd0, b ? err_b : err_a}, 32'd0);
      chk("count", b ? {29'd0, cnt_b} : {23'd0, cnt_a}, ec);
   endtask

   vec_t tbl[14];
   vec_t v;
   int   ea, ec;

   initial begin
      //          op     f3    f7     rd  rs1 rs2 imm           last ill exp
      tbl[0]  = '{7'h13, 3'd0, 7'h00, 1,  0,  0,  32'd5,        0,   0,  32'h00500093};
      tbl[1]  = '{7'h33, 3'd0, 7'h00, 3,  1,  2,  32'd0,        0,   0,  32'h002081B3};
      tbl[2]  = '{7'h23, 3'd2, 7'h00, 0,  1,  2,  32'd8,        0,   0,  32'h0020A423};
      tbl[3]  = '{7'h13, 3'd1, 7'h00, 1,  2,  0,  32'd3,        0,   0,  32'h00311093};
      tbl[4]  = '{7'h13, 3'd5, 7'h20, 1,  2,  0,  32'd3,        0,   0,  32'h40315093};
      tbl[5]  = '{7'h63, 3'd0, 7'h00, 0,  0,  0,  32'hFFFFFFFC, 0,   0,  32'hFE000EE3};
      tbl[6]  = '{7'h6F, 3'd0, 7'h00, 0,  0,  0,  32'hFFFFFFFC, 0,   0,  32'hFFDFF06F};
      tbl[7]  = '{7'h03, 3'd2, 7'h00, 5,  1,  0,  32'hFFFFFFFC, 0,   0,  32'hFFC0A283};
      tbl[8]  = '{7'h17, 3'd0, 7'h00, 1,  0,  0,  32'h00001000, 0,   0,  32'h00001097};
      tbl[9]  = '{7'h67, 3'd0, 7'h00, 0,  1,  0,  32'd0,        0,   0,  32'h00008067};
      tbl[10] = '{7'h37, 3'd7, 7'h55, 5,  31, 9,  32'h12345000, 0,   0,  32'h123452B7};
      tbl[11] = '{7'h7F, 3'd0, 7'h00, 1,  0,  0,  32'd0,        0,   1,  32'h0};
      tbl[12] = '{7'h63, 3'd0, 7'h00, 0,  1,  2,  32'd8,        0,   0,  32'h00208463};
      tbl[13] = '{7'h6F, 3'd0, 7'h00, 1,  0,  0,  32'h00000011, 1,   0,  32'h010000EF};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, rdy_a}, 32'd1);
      chk("rst_we",    {31'd0, we_a}, 32'd0);
      chk("rst_addr",  {24'd0, addr_a}, 32'd0);
      chk("rst_count", {23'd0, cnt_a}, 32'd0);
      chk("rst_wdata", wdata_a, 32'd0);
      chk("rst_flags", {29'd0, done_a, full_a, err_a}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      ea = 0; ec = 0;
      for (int i = 0; i < 14; i++) begin
         if (!tbl[i].ill) ec++;
         xfer(tbl[i], 1'b0, ea, ec);
         if (!tbl[i].ill) ea++;
      end
      chk("done_set", {31'd0, done_a}, 32'd1);
      chk("done_full", {31'd0, full_a}, 32'd0);
      chk("done_ready", {31'd0, rdy_a}, 32'd0);
      valid_a = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("done_no_we", {31'd0, we_a}, 32'd0);
      end
      valid_a = 1'b0;
      chk("done_cnt_hold", {23'd0, cnt_a}, 32'd13);

      // Clear after done
      clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      chk("clr_addr", {24'd0, addr_a}, 32'd0);
      chk("clr_done", {31'd0, done_a}, 32'd0);
      chk("clr_ready", {31'd0, rdy_a}, 32'd1);
      chk("clr_count", {23'd0, cnt_a}, 32'd0);

      // Reset arriving while a bundle sits in ENCODE
      send(tbl[0], 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_enc_we", {31'd0, we_a}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_enc_no_we", {31'd0, we_a}, 32'd0);
      end
      chk("rst_enc_addr", {24'd0, addr_a}, 32'd0);
      chk("rst_enc_cnt", {23'd0, cnt_a}, 32'd0);
      chk("rst_enc_wdata", wdata_a, 32'd0);
      chk("rst_enc_ready", {31'd0, rdy_a}, 32'd1);

      // DEPTH=4 instance: fill to full, address saturates at 3
      v = tbl[0];
      for (int i = 0; i < 4; i++) xfer(v, 1'b1, i, i + 1);
      chk("full_set", {31'd0, full_b}, 32'd1);
      chk("full_done", {31'd0, done_b}, 32'd0);
      chk("full_addr", {30'd0, addr_b}, 32'd3);
      chk("full_ready", {31'd0, rdy_b}, 32'd0);
      valid_b = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("full_no_we", {31'd0, we_b}, 32'd0);
      end
      valid_b = 1'b0;
      chk("full_cnt_hold", {29'd0, cnt_b}, 32'd4);

      // Last bundle coinciding with the final slot sets both done and full
      clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) xfer(v, 1'b1, i, i + 1);
      v.last = 1'b1;
      xfer(v, 1'b1, 3, 4);
      chk("both_done", {31'd0, done_b}, 32'd1);
      chk("both_full", {31'd0, full_b}, 32'd1);
      chk("both_addr", {30'd0, addr_b}, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

endmodule
